// File: rtl/pair_pkg.sv
// pair_pkg -- shared types and helpers for the pair deserializer.
//   PAIR_WIDTH : default width of each of the x and y fields
//   pair_t     : one assembled {x,y} pair at the default width (x in the upper half)
//   cnt_w()    : width of an occupancy counter that must hold 0..n inclusive
package pair_pkg;
  localparam int PAIR_WIDTH = 8;

  typedef struct packed {
    logic [PAIR_WIDTH-1:0] x;
    logic [PAIR_WIDTH-1:0] y;
  } pair_t;

  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/pair_deserializer_if.sv
// pair_deserializer_if -- serial-in / pair-out handshake bundle.
//   I_data, I_valid, I_ready : serial bit stream in (valid/ready)
//   O_x, O_y, O_valid, O_ready : assembled pair out (valid/ready)
//   master : the side that sends bits and consumes pairs
//   slave  : the deserializer itself
interface pair_deserializer_if
  import pair_pkg::*;
#(
  parameter int WIDTH = PAIR_WIDTH
);
  logic             I_data;
  logic             I_valid;
  logic             I_ready;
  logic [WIDTH-1:0] O_x;
  logic [WIDTH-1:0] O_y;
  logic             O_valid;
  logic             O_ready;

  modport master (
    output I_data, I_valid, O_ready,
    input  I_ready, O_x, O_y, O_valid
  );

  modport slave (
    input  I_data, I_valid, O_ready,
    output I_ready, O_x, O_y, O_valid
  );
endinterface

// File: rtl/pair_fifo.sv
// pair_fifo -- DEPTH-entry FIFO of W-bit words with registered full/empty.
//   clk, rst : clock, async active-high reset (clears pointers and occupancy)
//   push     : write wr_data (ignored while full)
//   pop      : drop the head entry (ignored while empty)
//   rd_data  : head entry, valid only while !empty
//   full     : DEPTH entries held
//   empty    : no entries held
module pair_fifo
  import pair_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage needs no reset: nothing reads it while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/pair_deserializer.sv
// pair_deserializer -- collects 2*WIDTH serial bits (LSB first, x then y)
// into {x,y} pairs and buffers them in a DEPTH-entry FIFO.
//   CLK        : clock
//   ASYNCRESET : async active-high reset; drops partial frame and buffered pairs
//   bus        : pair_deserializer_if.slave (serial in, pair out)
// I_ready depends only on registered FIFO state, never on O_ready.
module pair_deserializer
  import pair_pkg::*;
#(
  parameter int WIDTH = PAIR_WIDTH,
  parameter int DEPTH = 2
) (
  input logic                    CLK,
  input logic                    ASYNCRESET,
  pair_deserializer_if.slave     bus
);
  localparam int FW = 2 * WIDTH;
  localparam int BW = $clog2(FW);

  logic [BW-1:0] bit_cnt;
  logic [FW-2:0] shreg;    // the FW-1 most recent accepted bits
  logic [FW-1:0] frame;    // shreg plus the bit offered this cycle
  logic [FW-1:0] head;
  logic          accept, last, full, empty;

  assign bus.I_ready = ~full;
  assign accept      = bus.I_valid & ~full;
  assign last        = accept && (bit_cnt == BW'(FW - 1));
  // New bits enter at the top, so after FW shifts the first bit sits at bit 0.
  assign frame       = {bus.I_data, shreg};

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (accept) begin
      shreg   <= frame[FW-1:1];
      bit_cnt <= last ? '0 : bit_cnt + 1'b1;
    end
  end

  // Push the completed frame in the same cycle its final bit is accepted;
  // stored as {x,y} with x in the upper half.
  pair_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) pair_fifo_inst0 (
    .clk     (CLK),
    .rst     (ASYNCRESET),
    .push    (last),
    .wr_data ({frame[WIDTH-1:0], frame[FW-1:WIDTH]}),
    .pop     (bus.O_ready),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  // Zero the fields while empty so stale storage never shows after reset.
  assign bus.O_valid = ~empty;
  assign bus.O_x     = empty ? '0 : head[FW-1:WIDTH];
  assign bus.O_y     = empty ? '0 : head[WIDTH-1:0];
endmodule

// File: doc/pair_deserializer.md
PAIR_DESERIALIZER -- requirements
Module: pair_deserializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of each of the x and y fields.
REQ-002 SHALL have parameter DEPTH, default 2: pair FIFO depth in entries, power of two, at least 2.
REQ-003 SHALL have port CLK, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port ASYNCRESET, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port I_data, input, 1 bit: serial data bit.
REQ-006 SHALL have port I_valid, input, 1 bit: I_data holds a valid bit this cycle.
REQ-007 SHALL have port I_ready, output, 1 bit: block accepts a serial bit this cycle.
REQ-008 SHALL have port O_x, output, WIDTH bits: x field of the head pair.
REQ-009 SHALL have port O_y, output, WIDTH bits: y field of the head pair.
REQ-010 SHALL have port O_valid, output, 1 bit: O_x and O_y hold a valid pair.
REQ-011 SHALL have port O_ready, input, 1 bit: downstream consumes the head pair.

Function
REQ-012 SHALL accept one serial bit per cycle in which I_valid and I_ready are both high; I_data SHALL be ignored in all other cycles.
REQ-013 SHALL assemble each frame of 2*WIDTH accepted bits, LSB first: the first WIDTH bits form x, the next WIDTH bits form y.
REQ-014 SHALL keep a bit counter in the range 0..2*WIDTH-1; it increments on each accepted bit and wraps to 0 after bit 2*WIDTH-1.
REQ-015 SHALL write the completed {x,y} pair into the FIFO in the cycle it accepts the final (2*WIDTH-1) bit, so the pair is visible on O_* on the next cycle (1-cycle latency from final bit to O_valid).
REQ-016 SHALL drive I_ready = not FIFO-full (registered state only, no combinational path from O_ready).
REQ-017 SHALL drive O_valid = not FIFO-empty, with O_x and O_y presenting the head entry; O_x and O_y SHALL stay stable while O_valid is high and O_ready is low.
REQ-018 SHALL pop the head entry on each cycle in which O_valid and O_ready are both high.
REQ-019 SHALL perform a simultaneous push and pop in one cycle with the occupancy unchanged.
REQ-020 SHALL wrap the FIFO read and write pointers modulo DEPTH; occupancy SHALL be tracked with a counter of width clog2(DEPTH)+1.
REQ-021 SHALL, when full, hold I_ready low and preserve any partially assembled frame until space frees; I_ready SHALL rise in the cycle after the pop.
REQ-022 SHALL treat O_ready high while empty, or I_valid high while I_ready is low, as no-ops.

Reset
REQ-023 SHALL, on ASYNCRESET high, immediately clear the bit counter, the shift register, both FIFO pointers and the occupancy count.
REQ-024 SHALL hold O_valid = 0, O_x = 0, O_y = 0 and I_ready = 1 during reset and in the first cycle after it.
REQ-025 SHALL discard a partially assembled frame and all buffered pairs on reset mid-operation; the next accepted bit SHALL be bit 0 of x.

Structure
REQ-026 SHALL keep the pair type {x,y} (WIDTH each) and the counter width helper in the shared package pair_pkg.
REQ-027 SHALL instantiate exactly one sub-module, pair_fifo (DEPTH entries of 2*WIDTH bits, registered full/empty), under the instance name pair_fifo_inst0.

Verification
REQ-028 Bench SHALL cover, with WIDTH=8: serial bits of x=0xA5 then y=0x3C, O_ready=1 -> O_valid for exactly 1 cycle, 1 cycle after bit 15, with O_x=0xA5, O_y=0x3C.
REQ-029 Bench SHALL cover, with DEPTH=2 and O_ready=0: send 3 frames -> I_ready falls after frame 2 and frame 3 stalls at bit 0; assert O_ready -> pairs emerge in order 1,2,3 with nothing lost.
REQ-030 Bench SHALL cover: I_valid toggled randomly with 50 % gaps -> assembled pairs match the reference model bit-exactly.
REQ-031 Bench SHALL cover: assert ASYNCRESET mid-frame after bit 5 -> O_valid=0 at once, and the next 16 bits form a clean pair.
REQ-032 Bench SHALL cover: FIFO full, with a pop and the final bit offered in the same cycle -> no push that cycle, push on the next cycle, occupancy never above DEPTH.
